// File: rtl/gcd.sv
// Subtraction-based Euclid GCD engine for two 16-bit operands loaded serially on In.
// One compare/subtract step per clock; Out/Done are registered and hold until the next Start.
module gcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [15:0] In,
    output logic [15:0] Out,
    output logic        Done
);

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   out_q, out_d;
    logic           done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE, FIN: begin
                if (Start) begin
                    a_d     = In;
                    done_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (Start) begin
                    a_d = In;
                end else begin
                    b_d     = In;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Termination checks take priority over the subtract step
                if (a_q == b_q) begin
                    out_d   = a_q;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else if (a_q == '0) begin
                    out_d   = b_q;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else if (b_q == '0) begin
                    out_d   = a_q;
                    done_d  = 1'b1;
                    state_d = FIN;
                end else if (a_q > b_q) begin
                    a_d = W'(a_q - b_q);
                end else begin
                    b_d = W'(b_q - a_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Out  = out_q;
    assign Done = done_q;

endmodule

// File: tb/tb_gcd.sv
// Directed plus randomized checks of gcd against a division-based Euclid model
// that predicts both the result and the number of CALC edges to Done.
module tb_gcd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] In = 16'd0;
    logic [15:0] Out;
    logic        Done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gcd dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .In    (In),
        .Out   (Out),
        .Done  (Done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Each subtraction step reduces by one quotient unit; the final equal pair adds
    // the terminating edge, so latency equals the sum of Euclid quotients.
    function automatic int unsigned ref_lat(input int unsigned a, input int unsigned b);
        int unsigned x = a, y = b, t, sum = 0;
        if (a == 0 || b == 0) return 1;
        while (y != 0) begin
            sum += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return sum;
    endfunction

    // Load A then B, wait for Done, check Done fall, Out hold, result and latency
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
        logic [15:0] prev_out;
        int cnt;
        prev_out = Out;
        @(negedge clk); Start = 1'b1; In = a;
        @(negedge clk); Start = 1'b0; In = b;
        check({tag, ".done_fall"}, 32'(Done), 32'd0);
        @(negedge clk); In = 16'($urandom);
        check({tag, ".out_hold"}, 32'(Out), 32'(prev_out));
        cnt = 0;
        do begin
            @(negedge clk);
            In = 16'($urandom);
            cnt++;
        end while (!Done && cnt < 70000);
        check({tag, ".latency"}, 32'(cnt), ref_lat(a, b));
        check({tag, ".result"}, 32'(Out), ref_gcd(a, b));
    endtask

    initial begin
        logic [15:0] ra, rb;

        // Reset held two cycles
        repeat (2) @(negedge clk);
        check("rst.out", 32'(Out), 32'd0);
        check("rst.done", 32'(Done), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle.out", 32'(Out), 32'd0);
        check("idle.done", 32'(Done), 32'd0);

        // Basic and spec directed cases
        run_op(16'd6, 16'd4, "basic");
        repeat (5) @(negedge clk);
        check("basic.hold_out", 32'(Out), 32'd2);
        check("basic.hold_done", 32'(Done), 32'd1);
        run_op(16'd9, 16'd7, "coprime");
        run_op(16'd5, 16'd5, "equal");
        run_op(16'd1, 16'd10, "one_ten");
        run_op(16'd0, 16'd12, "zero_a");
        run_op(16'd8, 16'd0, "zero_b");
        run_op(16'd0, 16'd0, "zero_both");

        // Held Start: last A wins
        @(negedge clk); Start = 1'b1; In = 16'd3;
        @(negedge clk); In = 16'd7;
        @(negedge clk); In = 16'd10;
        @(negedge clk); Start = 1'b0; In = 16'd4;
        repeat (10) @(negedge clk);
        check("held.result", 32'(Out), 32'd2);
        check("held.done", 32'(Done), 32'd1);

        // Back-to-back from FIN: Out keeps 2 until new result
        run_op(16'd15, 16'd10, "b2b");
        check("b2b.final", 32'(Out), 32'd5);

        // Reset mid-CALC
        @(negedge clk); Start = 1'b1; In = 16'd65535;
        @(negedge clk); Start = 1'b0; In = 16'd1;
        repeat (101) @(negedge clk);
        check("long.busy", 32'(Done), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst.out", 32'(Out), 32'd0);
        check("midrst.done", 32'(Done), 32'd0);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst.idle_done", 32'(Done), 32'd0);
        check("midrst.idle_out", 32'(Out), 32'd0);
        run_op(16'd12, 16'd18, "after_rst");

        // Randomized operands
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom_range(0, 1000));
            rb = 16'($urandom_range(0, 1000));
            if (i % 8 == 3) ra = 16'd0;
            if (i % 8 == 5) rb = ra;
            run_op(ra, rb, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
